// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with run-time overlap select and input qualifier.
// Define SEQ_DET_CNT_EN to build the saturating match counter and its clear input.
module seq_detector_param #(
  parameter int             LEN     = 6,
  parameter logic [LEN-1:0] PATTERN = 6'b101011,
  parameter int             CNT_W   = 8,
  parameter int             PW      = $clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             z,
  output logic [PW-1:0]    state,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int PW1 = PW + 1;
  localparam int NS  = 2 ** PW;

  // Bit j of the pattern in arrival order (j = 0 is received first).
  function automatic logic pbit(input int j);
    logic [LEN-1:0] tmp;
    tmp = PATTERN >> (LEN - 1 - j);
    return tmp[0];
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, then b); LEN means a full match.
  function automatic int f_next(input int k, input logic b);
    int   res;
    logic ok;
    logic sb;
    res = 0;
    for (int m = 1; m <= k + 1; m++) begin
      ok = 1'b1;
      for (int i = 0; i < m; i++) begin
        sb = (k + 1 - m + i == k) ? b : pbit(k + 1 - m + i);
        if (sb != pbit(i)) ok = 1'b0;
      end
      if (ok) res = m;
    end
    return res;
  endfunction

  function automatic int f_border();
    int   res;
    logic ok;
    res = 0;
    for (int m = 1; m < LEN; m++) begin
      ok = 1'b1;
      for (int i = 0; i < m; i++)
        if (pbit(LEN - m + i) != pbit(i)) ok = 1'b0;
      if (ok) res = m;
    end
    return res;
  endfunction

  localparam logic [PW-1:0]  BORDER_S = PW'(f_border());
  localparam logic [PW1-1:0] LEN_P    = PW1'(LEN);

  // Transition table padded to a power of two so any state_q value indexes safely.
  logic [NS-1:0][PW1-1:0] nxt0, nxt1;

  for (genvar k = 0; k < NS; k++) begin : g_tab
    localparam int N0 = (k < LEN) ? f_next(k, 1'b0) : 0;
    localparam int N1 = (k < LEN) ? f_next(k, 1'b1) : 0;
    assign nxt0[k] = PW1'(N0);
    assign nxt1[k] = PW1'(N1);
  end

  logic [PW-1:0]  state_q, state_d;
  logic           z_q, z_d;
  logic [PW1-1:0] m_nxt;

  always_comb begin
    state_d = state_q;
    z_d     = 1'b0;
    m_nxt   = x ? nxt1[state_q] : nxt0[state_q];
    if ({1'b0, state_q} >= LEN_P) begin
      state_d = '0;
    end else if (x_valid) begin
      if (m_nxt == LEN_P) begin
        z_d     = 1'b1;
        state_d = overlap ? BORDER_S : '0;
      end else begin
        state_d = m_nxt[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
    end
  end

  assign z     = z_q;
  assign state = state_q;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear beats a coincident match; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)                  cnt_d = '0;
    else if (z_d && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign match_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus biased random traffic against a
// history-queue reference model; a second instance with CNT_W=2 covers counter saturation.
module tb_seq_detector_param;
  localparam int         LEN = 6;
  localparam logic [5:0] PAT = 6'b101011;
`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, x, x_valid, overlap, clr_cnt;
  logic       z, z2;
  logic [2:0] state, state2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int errors = 0;
  int checks = 0;

  // Reference model: accepted-bit history plus expected outputs.
  bit         hist[$];
  logic       ez;
  logic [2:0] es;
  logic [7:0] ec;
  logic [1:0] ec2;

  seq_detector_param u_dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .clr_cnt(clr_cnt), .z(z), .state(state), .match_cnt(match_cnt)
  );

  seq_detector_param #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .clr_cnt(clr_cnt), .z(z2), .state(state2), .match_cnt(match_cnt2)
  );

  always #5 clk = ~clk;

  function automatic logic pat_bit(input int j);
    logic [5:0] p;
    p = PAT >> (LEN - 1 - j);
    return p[0];
  endfunction

  function automatic bit tail_is_prefix(input int k);
    if (hist.size() < k) return 1'b0;
    for (int i = 0; i < k; i++)
      if (hist[hist.size() - k + i] != pat_bit(i)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick(input logic b, input logic v, input logic ov, input logic clr, input logic r);
    x = b; x_valid = v; overlap = ov; clr_cnt = clr; rst = r;
    @(posedge clk);
    if (!r) begin
      hist.delete(); ez = 1'b0; es = '0; ec = '0; ec2 = '0;
    end else begin
      ez = 1'b0;
      if (v) begin
        hist.push_back(b);
        if (hist.size() > LEN) void'(hist.pop_front());
        if (tail_is_prefix(LEN)) begin
          ez = 1'b1;
          if (!ov) hist.delete();
        end
        es = '0;
        for (int k = 1; k < LEN; k++) if (tail_is_prefix(k)) es = 3'(k);
      end
      if (CNT_ON) begin
        if (clr) begin
          ec = '0; ec2 = '0;
        end else if (ez) begin
          if (ec != 8'hFF) ec = ec + 8'd1;
          if (ec2 != 2'd3) ec2 = ec2 + 2'd1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      tick(1'($urandom), 1'($urandom), 1'b1, 1'($urandom), 1'b0);
      checks++;
      if (z !== 1'b0 || state !== 3'd0 || match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
        errors++;
        $display("FAIL reset cyc%0d: z=%0b state=%0d cnt=%0d cnt2=%0d, want all 0", i, z, state, match_cnt, match_cnt2);
      end
    end
  endtask

  task automatic test_single_match;
    logic [2:0] exp_st [6];
    exp_st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(pat_bit(i), 1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if (z !== (i == 5) || state !== exp_st[i] || match_cnt !== ec) begin
        errors++;
        $display("FAIL single_match bit%0d: z=%0b state=%0d cnt=%0d, want z=%0b state=%0d cnt=%0d",
                 i, z, state, match_cnt, (i == 5), exp_st[i], ec);
      end
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (z !== 1'b0 || match_cnt !== (CNT_ON ? 8'd1 : 8'd0)) begin
      errors++;
      $display("FAIL single_match_after: z=%0b cnt=%0d, want z=0 cnt=%0d", z, match_cnt, CNT_ON ? 1 : 0);
    end
  endtask

  task automatic test_overlap_modes;
    logic [10:0] s;
    int zc;
    s = 11'b10101101011;
    for (int ov = 0; ov < 2; ov++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      zc = 0;
      for (int i = 0; i < 11; i++) begin
        tick(s[10 - i], 1'b1, ov[0], 1'b0, 1'b1);
        zc += int'(z);
        checks++;
        if (z !== ez || state !== es || match_cnt !== ec) begin
          errors++;
          $display("FAIL overlap%0d bit%0d: z=%0b state=%0d cnt=%0d, want z=%0b state=%0d cnt=%0d",
                   ov, i, z, state, match_cnt, ez, es, ec);
        end
      end
      checks++;
      if (zc != (ov ? 2 : 1) || match_cnt !== (CNT_ON ? 8'(ov ? 2 : 1) : 8'd0) || (ov == 0 && state !== 3'd1)) begin
        errors++;
        $display("FAIL overlap%0d_totals: pulses=%0d cnt=%0d state=%0d, want pulses=%0d", ov, zc, match_cnt, state, ov ? 2 : 1);
      end
    end
  endtask

  task automatic test_gapped;
    int         zc;
    logic [2:0] held;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    zc = 0;
    for (int i = 0; i < 6; i++) begin
      tick(pat_bit(i), 1'b1, 1'b1, 1'b0, 1'b1);
      zc += int'(z);
      checks++;
      if (z !== ez || state !== es) begin
        errors++;
        $display("FAIL gapped bit%0d: z=%0b state=%0d, want z=%0b state=%0d", i, z, state, ez, es);
      end
      held = state;
      for (int g = 0; g < 3; g++) begin
        tick(pat_bit(i) ^ g[0] ^ 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        zc += int'(z);
        checks++;
        if (z !== 1'b0 || state !== held) begin
          errors++;
          $display("FAIL gapped gap%0d.%0d: z=%0b state=%0d, want z=0 state=%0d", i, g, z, state, held);
        end
      end
    end
    checks++;
    if (zc != 1) begin
      errors++;
      $display("FAIL gapped_pulses: got %0d, want 1", zc);
    end
  endtask

  task automatic test_saturation_clear;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 6; i++) tick(pat_bit(i), 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (match_cnt2 !== (CNT_ON ? 2'd3 : 2'd0) || match_cnt !== (CNT_ON ? 8'd5 : 8'd0)) begin
      errors++;
      $display("FAIL saturation: cnt2=%0d cnt=%0d, want cnt2=%0d cnt=%0d", match_cnt2, match_cnt, CNT_ON ? 3 : 0, CNT_ON ? 5 : 0);
    end
    for (int i = 0; i < 5; i++) tick(pat_bit(i), 1'b1, 1'b0, 1'b0, 1'b1);
    tick(pat_bit(5), 1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (z !== 1'b1 || match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL clear_vs_match: z=%0b cnt=%0d cnt2=%0d, want z=1 cnt=0 cnt2=0", z, match_cnt, match_cnt2);
    end
  endtask

  task automatic test_reset_mid;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(pat_bit(i), 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (state !== 3'd5) begin
      errors++;
      $display("FAIL reset_mid_pre: state=%0d, want 5", state);
    end
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (state !== 3'd1 || z !== 1'b0 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: state=%0d z=%0b cnt=%0d, want state=1 z=0 cnt=0", state, z, match_cnt);
    end
  endtask

  task automatic test_random;
    logic b;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      b = ($urandom_range(3) != 0) ? pat_bit(int'(es)) : 1'($urandom);
      tick(b, $urandom_range(3) != 0, 1'($urandom), $urandom_range(15) == 0, $urandom_range(63) != 0);
      checks++;
      if (z !== ez || state !== es || match_cnt !== ec || z2 !== ez || state2 !== es || match_cnt2 !== ec2) begin
        errors++;
        $display("FAIL random cyc%0d: z=%0b/%0b state=%0d/%0d cnt=%0d/%0d, want z=%0b state=%0d cnt=%0d cnt2=%0d",
                 i, z, z2, state, state2, match_cnt, match_cnt2, ez, es, ec, ec2);
      end
    end
  endtask

  initial begin
    rst = 1'b0; x = 1'b0; x_valid = 1'b0; overlap = 1'b0; clr_cnt = 1'b0;
    test_reset();
    test_single_match();
    test_overlap_modes();
    test_gapped();
    test_saturation_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
